// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_pkg
// Description : Shared constants for the multi-channel timer: register
//               offsets, CTRL bit positions, INT_STATUS address, reset
//               polarity and the channel mode encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package timer_pkg;

    // Per-channel register offsets (addr_i[3:0] within a 16-byte window)
    localparam logic [3:0] c_OFF_CTRL  = 4'h0;
    localparam logic [3:0] c_OFF_COUNT = 4'h4;
    localparam logic [3:0] c_OFF_VALUE = 4'h8;
    localparam logic [3:0] c_OFF_PRESC = 4'hC;

    // Global interrupt status register address (addr_i[7:0])
    localparam logic [7:0] c_INT_STATUS_ADDR = 8'h80;

    // CTRL register bit positions
    localparam int c_CTRL_EN   = 0;
    localparam int c_CTRL_IE   = 1;
    localparam int c_CTRL_PEND = 2;
    localparam int c_CTRL_MODE = 3;

    // Prescaler field width (PRESC[7:0])
    localparam int c_PRESC_W = 8;

    // Reset is asserted when rst equals this level
    localparam logic c_RST_ACTIVE = 1'b0;

    typedef enum logic [0:0] {
        MODE_ONESHOT  = 1'b0,
        MODE_PERIODIC = 1'b1
    } timer_mode_e;

endpackage : timer_pkg
`default_nettype wire

// File: rtl/timer_ch.sv
`default_nettype none
// ============================================================================
// Module      : timer_ch
// Description : One timer channel: CTRL/COUNT/VALUE/PRESC state, prescaled
//               tick generation, expiry detection and the pending flag.
//               The prescaler is built only when TIMER_PRESCALER_EN is
//               defined; otherwise every enabled cycle is a tick and PRESC
//               reads 0.
// Ports       : clk, rst (sync, active-low)
//               i_wr_ctrl / i_wr_value / i_wr_presc : decoded write strobes
//               i_wdata                             : write data
//               o_ctrl / o_count / o_value / o_presc: zero-extended readback
//               o_pending                           : pending flag
//               o_irq                               : pending & int_en
// Revision    : 1.0 - initial release
// ============================================================================
module timer_ch
    import timer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_wr_ctrl,
    input  logic        i_wr_value,
    input  logic        i_wr_presc,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_ctrl,
    output logic [31:0] o_count,
    output logic [31:0] o_value,
    output logic [31:0] o_presc,
    output logic        o_pending,
    output logic        o_irq
);

    logic               r_enable;
    logic               r_int_en;
    logic               r_pending;
    timer_mode_e        r_mode;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   r_value;

    logic               w_tick;
    logic               w_expire;
    logic               w_en_next;
    logic               w_unused_wdata;

    // Upper write-data bits are meaningless when CNT_W < 32
    assign w_unused_wdata = ^i_wdata;

`ifdef TIMER_PRESCALER_EN
    logic [c_PRESC_W-1:0] r_presc;
    logic [c_PRESC_W-1:0] r_pcnt;

    // ">=" rather than "==" so that lowering PRESC below the running
    // prescaler count ticks immediately instead of wrapping around.
    assign w_tick = r_enable && (r_pcnt >= r_presc);

    always_ff @(posedge clk) begin
        if (rst == c_RST_ACTIVE) begin
            r_presc <= '0;
            r_pcnt  <= '0;
        end else begin
            if (i_wr_presc) begin
                r_presc <= i_wdata[c_PRESC_W-1:0];
            end
            // Count only enabled cycles; restart after each tick and keep
            // at zero whenever the channel is (or is about to be) disabled.
            if (!r_enable || !w_en_next || w_tick) begin
                r_pcnt <= '0;
            end else begin
                r_pcnt <= r_pcnt + c_PRESC_W'(1);
            end
        end
    end

    always_comb begin
        o_presc = '0;
        o_presc[c_PRESC_W-1:0] = r_presc;
    end
`else
    logic w_unused_presc;

    assign w_unused_presc = i_wr_presc;
    assign w_tick         = r_enable;
    assign o_presc        = '0;
`endif

    assign w_expire = w_tick && (r_count >= r_value);

    // A CTRL write overrides the one-shot self-disable in the same cycle.
    always_comb begin
        w_en_next = r_enable;
        if (w_expire && (r_mode == MODE_ONESHOT)) begin
            w_en_next = 1'b0;
        end
        if (i_wr_ctrl) begin
            w_en_next = i_wdata[c_CTRL_EN];
        end
    end

    always_ff @(posedge clk) begin
        if (rst == c_RST_ACTIVE) begin
            r_enable  <= 1'b0;
            r_int_en  <= 1'b0;
            r_pending <= 1'b0;
            r_mode    <= MODE_ONESHOT;
            r_count   <= '0;
            r_value   <= '0;
        end else begin
            r_enable <= w_en_next;

            if (i_wr_ctrl) begin
                r_int_en <= i_wdata[c_CTRL_IE];
                r_mode   <= timer_mode_e'(i_wdata[c_CTRL_MODE]);
            end

            // Expiry sets pending even if a write-1-to-clear lands on it.
            if (w_expire) begin
                r_pending <= 1'b1;
            end else if (i_wr_ctrl && i_wdata[c_CTRL_PEND]) begin
                r_pending <= 1'b0;
            end

            if (i_wr_value) begin
                r_value <= i_wdata[CNT_W-1:0];
            end

            if (!w_en_next || w_expire) begin
                r_count <= '0;
            end else if (w_tick) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    always_comb begin
        o_ctrl = '0;
        o_ctrl[c_CTRL_EN]   = r_enable;
        o_ctrl[c_CTRL_IE]   = r_int_en;
        o_ctrl[c_CTRL_PEND] = r_pending;
        o_ctrl[c_CTRL_MODE] = (r_mode == MODE_PERIODIC);

        o_count = '0;
        o_count[CNT_W-1:0] = r_count;

        o_value = '0;
        o_value[CNT_W-1:0] = r_value;
    end

    assign o_pending = r_pending;
    assign o_irq     = r_pending & r_int_en;

endmodule : timer_ch
`default_nettype wire

// File: rtl/timer_nch.sv
`default_nettype none
// ============================================================================
// Module      : timer_nch
// Description : NUM_CH independent timer channels behind a small register
//               map. Channel n lives at n*0x10 (CTRL +0, COUNT +4, VALUE +8,
//               PRESC +C); INT_STATUS at 0x80. Holds address decode, the
//               combinational read mux and the interrupt OR.
//               Optional prescaler: define TIMER_PRESCALER_EN.
// Ports       : clk       - clock
//               rst       - synchronous reset, active low
//               data_i    - write data
//               addr_i    - byte address, only [7:0] decoded
//               we_i      - write strobe
//               data_o    - combinational read data for addr_i
//               int_sig_o - OR over channels of pending & int_en
// Revision    : 1.0 - initial release
// ============================================================================
module timer_nch
    import timer_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_i,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    output logic [31:0] data_o,
    output logic        int_sig_o
);

    logic [7:0]         w_addr;
    logic [3:0]         w_sel_ch;
    logic [3:0]         w_off;
    logic               w_unused_addr;

    logic [31:0]        w_ch_ctrl  [NUM_CH];
    logic [31:0]        w_ch_count [NUM_CH];
    logic [31:0]        w_ch_value [NUM_CH];
    logic [31:0]        w_ch_presc [NUM_CH];
    logic [NUM_CH-1:0]  w_pending;
    logic [NUM_CH-1:0]  w_irq;

    assign w_addr        = addr_i[7:0];
    assign w_sel_ch      = w_addr[7:4];
    assign w_off         = w_addr[3:0];
    assign w_unused_addr = ^addr_i[31:8];

    // INT_STATUS decodes as channel 8, which no channel index can match,
    // so writes there fall through and are ignored.
    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
            logic w_hit;

            assign w_hit = we_i && (w_sel_ch == 4'(g));

            timer_ch #(
                .CNT_W (CNT_W)
            ) u_ch (
                .clk        (clk),
                .rst        (rst),
                .i_wr_ctrl  (w_hit && (w_off == c_OFF_CTRL)),
                .i_wr_value (w_hit && (w_off == c_OFF_VALUE)),
                .i_wr_presc (w_hit && (w_off == c_OFF_PRESC)),
                .i_wdata    (data_i),
                .o_ctrl     (w_ch_ctrl[g]),
                .o_count    (w_ch_count[g]),
                .o_value    (w_ch_value[g]),
                .o_presc    (w_ch_presc[g]),
                .o_pending  (w_pending[g]),
                .o_irq      (w_irq[g])
            );
        end
    endgenerate

    always_comb begin
        data_o = '0;
        if (rst != c_RST_ACTIVE) begin
            if (w_addr == c_INT_STATUS_ADDR) begin
                data_o[NUM_CH-1:0] = w_pending;
            end else begin
                for (int n = 0; n < NUM_CH; n++) begin
                    if (w_sel_ch == 4'(n)) begin
                        case (w_off)
                            c_OFF_CTRL:  data_o = w_ch_ctrl[n];
                            c_OFF_COUNT: data_o = w_ch_count[n];
                            c_OFF_VALUE: data_o = w_ch_value[n];
                            c_OFF_PRESC: data_o = w_ch_presc[n];
                            default:     data_o = '0;
                        endcase
                    end
                end
            end
        end
    end

    assign int_sig_o = |w_irq;

endmodule : timer_nch
`default_nettype wire

// File: tb/tb_timer_nch.sv
`default_nettype none
// ============================================================================
// Module      : tb_timer_nch
// Description : Self-checking bench for timer_nch. Table-driven one-shot and
//               register-map vectors, hand-written periodic / prescaler /
//               collision / mid-count reset sequences, a second small
//               instance (2 channels, 16-bit), and randomized traffic
//               compared against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_nch;

    localparam int NCH = 4;
`ifdef TIMER_PRESCALER_EN
    localparam bit HAS_PRESC = 1'b1;
`else
    localparam bit HAS_PRESC = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] data_i, addr_i, data_o;
    logic        we_i, int_sig_o;
    logic [31:0] s_data_i, s_addr_i, s_data_o;
    logic        s_we_i, s_int_sig_o;

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    timer_nch #(.NUM_CH(NCH), .CNT_W(32)) u_dut (
        .clk(clk), .rst(rst), .data_i(data_i), .addr_i(addr_i),
        .we_i(we_i), .data_o(data_o), .int_sig_o(int_sig_o)
    );

    timer_nch #(.NUM_CH(2), .CNT_W(16)) u_small (
        .clk(clk), .rst(rst), .data_i(s_data_i), .addr_i(s_addr_i),
        .we_i(s_we_i), .data_o(s_data_o), .int_sig_o(s_int_sig_o)
    );

    // ---------------- behavioural model ----------------
    logic        m_en   [NCH];
    logic        m_ie   [NCH];
    logic        m_pend [NCH];
    logic        m_mode [NCH];
    logic [31:0] m_cnt  [NCH];
    logic [31:0] m_val  [NCH];
    logic [31:0] m_presc[NCH];
    int          m_elapsed[NCH];   // enabled cycles since last tick

    function automatic void m_reset();
        for (int c = 0; c < NCH; c++) begin
            m_en[c] = 0; m_ie[c] = 0; m_pend[c] = 0; m_mode[c] = 0;
            m_cnt[c] = 0; m_val[c] = 0; m_presc[c] = 0; m_elapsed[c] = 0;
        end
    endfunction

    function automatic logic [31:0] m_read(logic [31:0] a);
        logic [7:0]  b;
        logic [31:0] r;
        int          ch;
        b = a[7:0];
        r = '0;
        if (rst !== 1'b1) return '0;
        if (b == 8'h80) begin
            for (int c = 0; c < NCH; c++) r[c] = m_pend[c];
            return r;
        end
        ch = int'(b[7:4]);
        if (ch >= NCH) return '0;
        case (b[3:0])
            4'h0: r = {28'd0, m_mode[ch], m_pend[ch], m_ie[ch], m_en[ch]};
            4'h4: r = m_cnt[ch];
            4'h8: r = m_val[ch];
            4'hC: r = HAS_PRESC ? m_presc[ch] : 32'd0;
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic m_int();
        logic r;
        r = 1'b0;
        for (int c = 0; c < NCH; c++) r = r | (m_pend[c] & m_ie[c]);
        return r;
    endfunction

    function automatic void m_clock(logic we, logic [31:0] a, logic [31:0] d);
        int  period;
        bit  wr_ctrl, tick, expire, new_en;
        if (rst !== 1'b1) begin
            m_reset();
            return;
        end
        for (int c = 0; c < NCH; c++) begin
            period  = HAS_PRESC ? int'(m_presc[c]) + 1 : 1;
            wr_ctrl = we && (a[7:0] == 8'(c * 16));
            tick    = m_en[c] && (m_elapsed[c] + 1 >= period);
            expire  = tick && (m_cnt[c] >= m_val[c]);
            new_en  = m_en[c];
            if (expire && !m_mode[c]) new_en = 0;
            if (wr_ctrl) new_en = d[0];
            if (expire) m_pend[c] = 1;
            else if (wr_ctrl && d[2]) m_pend[c] = 0;
            if (wr_ctrl) begin
                m_ie[c]   = d[1];
                m_mode[c] = d[3];
            end
            if (tick) begin
                m_cnt[c]     = expire ? 32'd0 : m_cnt[c] + 1;
                m_elapsed[c] = 0;
            end else if (m_en[c]) begin
                m_elapsed[c]++;
            end
            if (!new_en) begin
                m_cnt[c]     = 0;
                m_elapsed[c] = 0;
            end
            m_en[c] = new_en;
            if (we && a[7:0] == 8'(c * 16 + 8))  m_val[c]   = d;
            if (we && a[7:0] == 8'(c * 16 + 12)) m_presc[c] = {24'd0, d[7:0]};
        end
    endfunction

    // ---------------- helpers ----------------
    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One clock cycle on the main DUT: drive, optionally check at negedge,
    // advance the model at the active edge.
    task automatic cyc(input string name, input logic we, input logic [31:0] a,
                       input logic [31:0] d, input bit chk,
                       input logic [31:0] exp_d, input logic exp_int,
                       output logic [31:0] rd);
        we_i = we; addr_i = a; data_i = d;
        @(negedge clk);
        rd = data_o;
        if (chk) begin
            check32({name, " data"}, data_o, exp_d);
            check32({name, " int"}, {31'd0, int_sig_o}, {31'd0, exp_int});
        end
        @(posedge clk);
        m_clock(we, a, d);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; we_i = 1'b0; s_we_i = 1'b0;
        @(posedge clk);
        m_reset();
        #1;
        rst = 1'b1;
    endtask

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [31:0] exp_d;
        logic        exp_int;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic we, logic [7:0] a, logic [31:0] d,
                                logic [31:0] ed, logic ei);
        vec_t v;
        v.we = we; v.addr = a; v.data = d; v.exp_d = ed; v.exp_int = ei;
        tbl.push_back(v);
    endfunction

    logic [31:0] rd;
    int          hits[$];
    logic [7:0]  rand_addrs[$];

    initial begin
        rst = 1'b0; we_i = 0; addr_i = 0; data_i = 0;
        s_we_i = 0; s_addr_i = 0; s_data_i = 0;
        m_reset();

        // ---- one-shot on ch0 + register-map vectors (from reset) ----
        add(0, 8'h00, 0, 32'h0, 0);   // reset state
        add(0, 8'h80, 0, 32'h0, 0);
        add(0, 8'h0C, 0, 32'h0, 0);
        add(1, 8'h08, 5, 32'h0, 0);   // VALUE=5
        add(1, 8'h00, 3, 32'h0, 0);   // enable, int_en, one-shot
        for (int k = 0; k < 6; k++) add(0, 8'h04, 0, 32'(k), 0);
        add(0, 8'h00, 0, 32'h6, 1);   // enable cleared, pending set
        add(0, 8'h80, 0, 32'h1, 1);
        add(0, 8'h04, 0, 32'h0, 1);
        add(1, 8'h00, 4, 32'h6, 1);   // clear pending
        add(0, 8'h00, 0, 32'h0, 0);
        add(0, 8'h80, 0, 32'h0, 0);
        add(0, 8'h44, 0, 32'h0, 0);   // channel 4 absent
        add(1, 8'h04, 32'h55, 32'h0, 0); // COUNT read-only
        add(0, 8'h04, 0, 32'h0, 0);
        add(1, 8'h80, 32'hF, 32'h0, 0);  // INT_STATUS read-only
        add(0, 8'h80, 0, 32'h0, 0);
        add(1, 8'h01, 32'h3, 32'h0, 0);  // unmapped
        add(0, 8'h00, 0, 32'h0, 0);
        add(0, 8'h08, 0, 32'h5, 0);

        do_reset();
        for (int i = 0; i < tbl.size(); i++)
            cyc($sformatf("vec%0d", i), tbl[i].we, {24'hA5A5A5, tbl[i].addr},
                tbl[i].data, 1, tbl[i].exp_d, tbl[i].exp_int, rd);

        // ---- periodic on ch1, then clear/expiry collision ----
        do_reset();
        cyc("per val", 1, 32'h18, 3, 1, 0, 0, rd);
        cyc("per ctrl", 1, 32'h10, 32'hB, 1, 0, 0, rd);
        for (int k = 0; k < 9; k++)
            cyc($sformatf("per count%0d", k), 0, 32'h14, 0, 1, 32'(k % 4), k >= 4, rd);
        cyc("per ctrl rd", 0, 32'h10, 0, 1, 32'hF, 1, rd);
        // Write clear every cycle: pending survives only the expiry cycle.
        for (int j = 0; j < 11; j++) begin
            bit p;
            p = (j == 0) || (j % 4 == 2);
            cyc($sformatf("per clr%0d", j), 1, 32'h10, 32'hF, 1,
                p ? 32'hF : 32'hB, p, rd);
        end
        cyc("per off", 1, 32'h10, 32'h0, 1, 32'hB, 0, rd);
        cyc("per off rd", 0, 32'h10, 0, 1, 32'h0, 0, rd);
        cyc("per cnt held", 0, 32'h14, 0, 1, 32'h0, 0, rd);

        // ---- prescaler on ch2 ----
        do_reset();
        cyc("psc wr", 1, 32'h2C, 32'hFFFF_FF03, 1, 0, 0, rd);
        cyc("psc rd", 0, 32'h2C, 0, 1, HAS_PRESC ? 32'h3 : 32'h0, 0, rd);
        cyc("psc val", 1, 32'h28, 2, 1, 0, 0, rd);
        cyc("psc ctrl", 1, 32'h20, 32'hB, 1, 0, 0, rd);
        hits.delete();
        for (int t = 0; t < 40; t++) begin
            cyc("psc run", 1, 32'h20, 32'hF, 0, 0, 0, rd);
            if (rd[2]) hits.push_back(t);
        end
        checks++;
        if (hits.size() < 2) begin
            errors++;
            $display("FAIL psc expiries: got %0d expected >=2", hits.size());
        end else begin
            check32("psc first", 32'(hits[0]), HAS_PRESC ? 32'd12 : 32'd3);
            check32("psc period", 32'(hits[1] - hits[0]), HAS_PRESC ? 32'd12 : 32'd3);
        end

        // ---- reset mid-count ----
        do_reset();
        cyc("mr ch0", 1, 32'h00, 32'h3, 1, 0, 0, rd);   // VALUE 0: expires at once
        cyc("mr val", 1, 32'h38, 100, 1, 0, 0, rd);
        cyc("mr ctrl", 1, 32'h30, 32'h3, 1, 0, 1, rd);
        for (int k = 0; k < 7; k++)
            cyc($sformatf("mr count%0d", k), 0, 32'h34, 0, 1, 32'(k), 1, rd);
        rst = 1'b0; we_i = 0; addr_i = 32'h34;
        @(negedge clk);
        check32("mr data in reset", data_o, 32'h0);
        @(posedge clk);
        m_reset();
        #1;
        rst = 1'b1;
        cyc("mr count after", 0, 32'h34, 0, 1, 0, 0, rd);
        cyc("mr ctrl after", 0, 32'h30, 0, 1, 0, 0, rd);
        cyc("mr val after", 0, 32'h38, 0, 1, 0, 0, rd);
        cyc("mr stat after", 0, 32'h80, 0, 1, 0, 0, rd);

        // ---- small instance: 2 channels, 16-bit ----
        s_we_i = 1; s_addr_i = 32'h08; s_data_i = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        s_we_i = 1; s_addr_i = 32'h28; s_data_i = 32'h1234;
        @(posedge clk); #1;
        s_we_i = 1; s_addr_i = 32'h18; s_data_i = 32'h0001_2345;
        @(posedge clk); #1;
        s_we_i = 0; s_addr_i = 32'h08;
        @(negedge clk); check32("small val0", s_data_o, 32'h0000_FFFF);
        s_addr_i = 32'h20;
        @(negedge clk); check32("small ch2 ctrl", s_data_o, 32'h0);
        s_addr_i = 32'h28;
        @(negedge clk); check32("small ch2 val", s_data_o, 32'h0);
        s_addr_i = 32'h18;
        @(negedge clk); check32("small val1", s_data_o, 32'h0000_2345);
        @(posedge clk); #1;

        // ---- randomized traffic against the model ----
        do_reset();
        rand_addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C,
                       8'h20, 8'h24, 8'h28, 8'h2C, 8'h30, 8'h34, 8'h38, 8'h3C,
                       8'h80, 8'h44, 8'h48, 8'h02, 8'hFC};
        for (int i = 0; i < 600; i++) begin
            logic        we;
            logic [7:0]  b;
            logic [31:0] a, d;
            we = ($urandom_range(0, 9) < 4);
            b  = rand_addrs[$urandom_range(0, rand_addrs.size() - 1)];
            a  = {$urandom_range(0, 255) == 0 ? 24'hFFFFFF : 24'h0, b};
            case (b[3:0])
                4'h0:    d = 32'($urandom_range(0, 15)) | ($urandom_range(0, 3) == 0 ? ($urandom & 32'hFFFF_FFF0) : 32'h0);
                4'h8:    d = ($urandom_range(0, 15) == 0) ? 32'($urandom) : 32'($urandom_range(0, 6));
                4'hC:    d = 32'($urandom_range(0, 3)) | ($urandom & 32'hFFFF_FF00);
                default: d = $urandom;
            endcase
            cyc("rand", we, a, d, 1, m_read(a), m_int(), rd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_timer_nch
`default_nettype wire
